// File: rtl/tx_os_scheduler_pkg.sv
// Shared symbol codes, sync header codes and FSM encoding for the TX ordered-set scheduler.
package tx_sched_pkg;

    localparam logic [7:0] SYM_COM     = 8'hBC;
    localparam logic [7:0] SYM_SKP     = 8'h1C;
    localparam logic [7:0] SYM_SKPGEN3 = 8'hAA;
    localparam logic [7:0] SYM_SKP_END = 8'hE1;
    localparam logic [7:0] SYM_IDL     = 8'h00;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_OS   = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t S_DATA     = 2'd0;
    localparam state_t S_LTSSM_OS = 2'd1;
    localparam state_t S_SKP      = 2'd2;

    // {K, symbol} at position idx of a SKP ordered set
    function automatic logic [8:0] skp_symbol(input logic gen3, input logic [3:0] idx);
        if (!gen3)
            return (idx == 4'd0) ? {1'b1, SYM_COM} : {1'b1, SYM_SKP};
        if (idx < 4'd12)
            return {1'b0, SYM_SKPGEN3};
        if (idx == 4'd12)
            return {1'b0, SYM_SKP_END};
        return {1'b0, SYM_IDL};
    endfunction

endpackage

// File: rtl/tx_os_scheduler_skp_interval_counter.sv
// Saturating SKP interval counter; pending stays set until the SKP ordered set completes.
module skp_interval_counter #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] incr,
    input  logic [CNT_W-1:0] threshold,
    input  logic             clear,
    output logic             pending
);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   sum;
    logic             reached;

    always_comb begin
        sum     = {1'b0, count} + {1'b0, incr};
        reached = (sum >= {1'b0, threshold});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            pending <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            pending <= 1'b0;
        end else begin
            count   <= reached ? threshold : sum[CNT_W-1:0];
            pending <= pending | reached;
        end
    end

endmodule

// File: rtl/tx_os_scheduler.sv
// Merges link data, LTSSM ordered sets and periodic SKP ordered sets into one
// continuous word stream for Gen1/2 (8b/10b) and Gen3+ (128b/130b) links.
module tx_os_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL      = 1180,
    parameter int unsigned SKP_INTERVAL_GEN3 = 370
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  GEN,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [31:0] lnkData,
    input  logic [3:0]  lnkDataK,
    input  logic        lnkValid,
    output logic        lnkReady,
    input  logic        ltssmOsReq,
    input  logic [31:0] ltssmOsData,
    input  logic [3:0]  ltssmOsDataK,
    input  logic        ltssmOsLast,
    output logic        ltssmOsAck,
    output logic [31:0] masterData,
    output logic [3:0]  masterDataK,
    output logic [1:0]  syncHeader,
    output logic        masterValid,
    output logic        turnOff
);

    localparam int unsigned MAX_INTERVAL =
        (SKP_INTERVAL > SKP_INTERVAL_GEN3) ? SKP_INTERVAL : SKP_INTERVAL_GEN3;
    localparam int unsigned CNT_W = $clog2(MAX_INTERVAL + 33);

    state_t      state, cur;
    logic [3:0]  sidx, bpos, blk_last_pos, skp_last_idx, skp_base;
    logic [2:0]  gen_q;
    logic [5:0]  pw_q;
    logic        cfg_vld, cfg_chg, gen3, boundary, skp_last, pending;
    logic [1:0]  wsh;
    logic [3:0]  lmask, nk;
    logic [31:0] dmask, nd;
    logic [1:0]  nsh;
    logic [8:0]  sym;
    logic [CNT_W-1:0] incr, threshold;

    always_comb begin
        gen3 = (GEN >= 3'd3);
        unique case (PIPEWIDTH)
            6'd32:   wsh = 2'd2;
            6'd16:   wsh = 2'd1;
            default: wsh = 2'd0;
        endcase
        lmask        = (wsh == 2'd2) ? 4'b1111 : (wsh == 2'd1) ? 4'b0011 : 4'b0001;
        dmask        = {{8{lmask[3]}}, {8{lmask[2]}}, {8{lmask[1]}}, {8{lmask[0]}}};
        blk_last_pos = 4'd15 >> wsh;
        skp_last_idx = gen3 ? blk_last_pos : (4'd3 >> wsh);
        skp_base     = sidx << wsh;
        skp_last     = (sidx == skp_last_idx);
        boundary     = !gen3 || (bpos == '0);
        cfg_chg      = cfg_vld && ((GEN != gen_q) || (PIPEWIDTH != pw_q));
    end

    // cur is the state of the word being produced this cycle; decisions only at boundaries
    always_comb begin
        cur = state;
        if (cfg_chg)
            cur = S_DATA;
        else if (state == S_DATA && boundary) begin
            if (pending)
                cur = S_SKP;
            else if (ltssmOsReq)
                cur = S_LTSSM_OS;
        end
    end

    assign lnkReady   = reset_n && (cur == S_DATA);
    assign ltssmOsAck = reset_n && (cur == S_LTSSM_OS) && ltssmOsReq;

    always_comb begin
        nd  = '0;
        nk  = '0;
        nsh = SH_NONE;
        sym = '0;
        unique case (cur)
            S_LTSSM_OS: begin
                nd = ltssmOsData & dmask;
                nk = ltssmOsDataK & lmask;
                if (gen3 && bpos == '0)
                    nsh = SH_OS;
            end
            S_SKP: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    sym = skp_symbol(gen3, skp_base + 4'(i));
                    if (lmask[i[1:0]]) begin
                        nd[8*i +: 8] = sym[7:0];
                        nk[i[1:0]]   = sym[8];
                    end
                end
                if (gen3 && bpos == '0)
                    nsh = SH_OS;
            end
            default: begin
                if (lnkValid) begin
                    nd = lnkData & dmask;
                    nk = lnkDataK & lmask;
                end
                if (gen3 && bpos == '0)
                    nsh = SH_DATA;
            end
        endcase
    end

    always_comb begin
        incr      = gen3 ? CNT_W'(bpos == '0) : (CNT_W'(1) << wsh);
        threshold = gen3 ? CNT_W'(SKP_INTERVAL_GEN3) : CNT_W'(SKP_INTERVAL);
    end

    skp_interval_counter #(
        .CNT_W(CNT_W)
    ) u_skp_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .incr     (incr),
        .threshold(threshold),
        .clear    (cfg_chg || (cur == S_SKP && skp_last)),
        .pending  (pending)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_DATA;
            sidx        <= '0;
            bpos        <= '0;
            masterData  <= '0;
            masterDataK <= '0;
            syncHeader  <= SH_NONE;
            masterValid <= 1'b0;
            turnOff     <= 1'b0;
            cfg_vld     <= 1'b0;
            gen_q       <= '0;
            pw_q        <= '0;
        end else begin
            masterData  <= nd;
            masterDataK <= nk;
            syncHeader  <= nsh;
            masterValid <= 1'b1;
            turnOff     <= (cur == S_LTSSM_OS);
            cfg_vld     <= 1'b1;
            gen_q       <= GEN;
            pw_q        <= PIPEWIDTH;
            if (cfg_chg) begin
                state <= S_DATA;
                sidx  <= '0;
                bpos  <= '0;
            end else begin
                bpos <= (!gen3 || bpos == blk_last_pos) ? '0 : bpos + 4'd1;
                unique case (cur)
                    S_SKP: begin
                        state <= skp_last ? S_DATA : S_SKP;
                        sidx  <= skp_last ? '0 : sidx + 4'd1;
                    end
                    S_LTSSM_OS: begin
                        state <= (ltssmOsReq && ltssmOsLast) ? S_DATA : S_LTSSM_OS;
                        sidx  <= '0;
                    end
                    default: begin
                        state <= S_DATA;
                        sidx  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
